mc_control_unit: RTL and testbench

Multi-cycle control FSM for the IBMinator MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. At each step it drives the mux selects, ALU-source/op codes, register-file and memory strobes that steer the shared adder/ALU, sign-extend and shift-left-2 paths. It sits between the instruction register (opcode/funct), the ALU zero flag, the unified memory handshake and every datapath control point.

---
 rtl/mc_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the IBMinator MIPS datapath.
// Walks each instruction through fetch, decode, execute, memory and
// writeback. It drives every mux select, ALU code and strobe on the shared
// datapath. The state is registered. Outputs are decoded combinationally
// from the state, plus mem_ready/zero/opcode where a step depends on them.
module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_WB   = 4'd10
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   is_store;
    logic   next_is_store;

    // Next-state selection. The opcode is only looked at in DECODE and
    // EXECUTE. The lw/sw choice is captured in DECODE so that MEM_ADDR does
    // not depend on the IR.
    always_comb begin
        next_state    = cur_state;
        next_is_store = is_store;
        case (cur_state)
            FETCH: begin
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                next_is_store = (opcode == OP_SW);
                case (opcode)
                    OP_RTYPE: next_state = EXECUTE;
                    OP_ADDI:  next_state = EXECUTE;
                    OP_LW:    next_state = MEM_ADDR;
                    OP_SW:    next_state = MEM_ADDR;
                    OP_BEQ:   next_state = BRANCH;
                    OP_J:     next_state = JUMP;
                    default:  next_state = FETCH;
                endcase
            end
            MEM_ADDR:  next_state = is_store ? MEM_WRITE : MEM_READ;
            MEM_READ:  next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   next_state = (opcode == OP_ADDI) ? ADDI_WB : ALU_WB;
            ALU_WB:    next_state = FETCH;
            ADDI_WB:   next_state = FETCH;
            BRANCH:    next_state = FETCH;
            JUMP:      next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    // State register. Reset aborts any instruction, including a pending
    // memory wait, and returns the FSM to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
            is_store  <= 1'b0;
        end else begin
            cur_state <= next_state;
            is_store  <= next_is_store;
        end
    end

    // Per-state control decode. Every output is held at 0 while reset is
    // asserted. Without that gating, FETCH would raise mem_req during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    if (opcode == OP_ADDI) begin
                        alu_src_b = 2'b10;
                    end else begin
                        alu_op = 2'b10;
                    end
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit. A reference model expands each
// instruction into its expected state walk and per-cycle control word.
// Randomized instruction streams are then checked against that model.
module tb_mc_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;

    int vectors;
    int miscompares;

    // State numbers as published in the interface
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3;
    localparam int S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXECUTE = 6, S_ALU_WB = 7;
    localparam int S_BRANCH = 8, S_JUMP = 9, S_ADDI_WB = 10;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    mc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {mem_req, mem_we, iord, ir_write, pc_en, pc_src,
    // alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal}
    function automatic logic [16:0] observed_word();
        return {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};
    endfunction

    function automatic logic [16:0] make_word(
        logic req, logic we, logic io, logic irw, logic pce, logic [1:0] psrc,
        logic sa, logic [1:0] sb, logic [1:0] op, logic rd, logic m2r,
        logic rw, logic ill);
        return {req, we, io, irw, pce, psrc, sa, sb, op, rd, m2r, rw, ill};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI;
    endfunction

    // Control word that each step of an instruction is expected to present
    function automatic logic [16:0] expected_word(int st, logic mr, logic z, logic [5:0] op);
        case (st)
            S_FETCH:     return make_word(1, 0, 0, mr, mr, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
            S_DECODE:    return make_word(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, !is_legal(op));
            S_MEM_ADDR:  return make_word(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
            S_MEM_READ:  return make_word(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
            S_MEM_WB:    return make_word(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1, 0);
            S_MEM_WRITE: return make_word(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
            S_EXECUTE:   return (op == OP_ADDI)
                             ? make_word(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0)
                             : make_word(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0);
            S_ALU_WB:    return make_word(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
            S_ADDI_WB:   return make_word(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);
            S_BRANCH:    return make_word(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0);
            S_JUMP:      return make_word(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0);
            default:     return '0;
        endcase
    endfunction

    task automatic checkOutput(string tag, int exp_state, logic [16:0] exp_word);
        vectors++;
        assert (state === exp_state[3:0]) else begin
            miscompares++;
            $error("[TB] FAIL %s state: got %0d expected %0d", tag, state, exp_state);
        end
        vectors++;
        assert (observed_word() === exp_word) else begin
            miscompares++;
            $error("[TB] FAIL %s controls (state %0d): got %b expected %b", tag, exp_state,
                   observed_word(), exp_word);
        end
    endtask

    // Runs one instruction. wf/wm are the memory wait cycles in FETCH and
    // in the data access. zsel picks the zero flag: 0/1 fixed, 2 random.
    // Returns the number of cycles the instruction took.
    task automatic applyStimulus(string tag, logic [5:0] op, int wf, int wm, int zsel,
                                 output int cycles);
        int   walk[$];
        bit   last_of_wait[$];
        logic mr;
        logic z;
        for (int i = 0; i <= wf; i++) begin
            walk.push_back(S_FETCH);
            last_of_wait.push_back(i == wf);
        end
        walk.push_back(S_DECODE);
        last_of_wait.push_back(0);
        if (op == OP_LW || op == OP_SW) begin
            walk.push_back(S_MEM_ADDR);
            last_of_wait.push_back(0);
            for (int i = 0; i <= wm; i++) begin
                walk.push_back(op == OP_LW ? S_MEM_READ : S_MEM_WRITE);
                last_of_wait.push_back(i == wm);
            end
            if (op == OP_LW) begin
                walk.push_back(S_MEM_WB);
                last_of_wait.push_back(0);
            end
        end else if (op == OP_R || op == OP_ADDI) begin
            walk.push_back(S_EXECUTE);
            walk.push_back(op == OP_R ? S_ALU_WB : S_ADDI_WB);
            last_of_wait.push_back(0);
            last_of_wait.push_back(0);
        end else if (op == OP_BEQ) begin
            walk.push_back(S_BRANCH);
            last_of_wait.push_back(0);
        end else if (op == OP_J) begin
            walk.push_back(S_JUMP);
            last_of_wait.push_back(0);
        end
        cycles = walk.size();
        opcode = op;
        for (int i = 0; i < walk.size(); i++) begin
            if (walk[i] == S_FETCH || walk[i] == S_MEM_READ || walk[i] == S_MEM_WRITE)
                mr = last_of_wait[i];
            else
                mr = 1'($urandom_range(1, 0));
            z = (zsel == 2) ? 1'($urandom_range(1, 0)) : 1'(zsel);
            mem_ready = mr;
            zero      = z;
            #1;
            checkOutput(tag, walk[i], expected_word(walk[i], mr, z, op));
            @(negedge clk);
        end
    endtask

    logic [5:0] legal_ops [6];
    int         cyc;
    logic [5:0] rop;

    initial begin
        vectors     = 0;
        miscompares = 0;
        legal_ops   = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        reset       = 1'b1;
        opcode      = 6'd0;
        zero        = 1'b0;
        mem_ready   = 1'b1;

        // Held reset: everything quiet, even with mem_ready asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            checkOutput("reset_hold", S_FETCH, '0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed walks from the test plan
        applyStimulus("lw_wait2", OP_LW, 0, 2, 2, cyc);
        vectors++;
        assert (cyc == 7) else begin
            miscompares++;
            $error("[TB] FAIL lw_cycles: got %0d expected 7", cyc);
        end
        applyStimulus("sw", OP_SW, 0, 0, 2, cyc);
        applyStimulus("beq_taken", OP_BEQ, 0, 0, 1, cyc);
        applyStimulus("beq_not_taken", OP_BEQ, 0, 0, 0, cyc);
        applyStimulus("rtype", OP_R, 0, 0, 2, cyc);
        applyStimulus("addi", OP_ADDI, 0, 0, 2, cyc);
        applyStimulus("illegal", 6'b111111, 0, 0, 2, cyc);
        applyStimulus("jump", OP_J, 0, 0, 2, cyc);
        applyStimulus("fetch_wait", OP_R, 3, 0, 2, cyc);

        // Randomized stream, including occasional unsupported opcodes
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(7, 0) == 0) begin
                do rop = 6'($urandom); while (is_legal(rop));
            end else begin
                rop = legal_ops[$urandom_range(5, 0)];
            end
            applyStimulus("random", rop, $urandom_range(2, 0), $urandom_range(3, 0), 2, cyc);
        end

        // Reset while stalled in MEM_WRITE aborts at once
        opcode = OP_SW;
        mem_ready = 1'b1;
        #1;
        checkOutput("abort_fetch", S_FETCH, expected_word(S_FETCH, 1'b1, zero, OP_SW));
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checkOutput("abort_stall", S_MEM_WRITE, expected_word(S_MEM_WRITE, 1'b0, zero, OP_SW));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_reset", S_FETCH, '0);
        @(negedge clk);
        #1;
        checkOutput("abort_reset_hold", S_FETCH, '0);
        reset = 1'b0;
        #1;
        checkOutput("after_release", S_FETCH, expected_word(S_FETCH, 1'b0, zero, OP_SW));
        @(negedge clk);
        applyStimulus("post_reset_lw", OP_LW, 1, 1, 2, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
